i2c_bus_arbiter: RTL and testbench

//  Shares one open-drain I2C pad pair (scl/sda) among PORT_COUNT I2CMaster instances
//  (e.g. the clock-synthesizer configurator and the redriver configurator) on one board bus.

---
 rtl/i2c_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner of one open-drain I2C pad pair shared by several I2C masters.
// A grant is only issued after the pads have been continuously released for tBUF.
module i2c_bus_arbiter #(
   parameter int unsigned CLOCK_FREQUENCY  = 0,
   parameter int          PORT_COUNT       = 2,
   parameter int unsigned BUS_FREE_TIME_NS = 5000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [PORT_COUNT-1:0] request,
   output logic [PORT_COUNT-1:0] grant,
   input  logic [PORT_COUNT-1:0] port_scl_output,
   input  logic [PORT_COUNT-1:0] port_sda_output,
   input  logic                  scl_input,
   input  logic                  sda_input,
   output logic                  scl_output,
   output logic                  sda_output,
   output logic                  busy,
   output logic [2:0]            owner
);

   // kHz first, then ceil(kHz * ns / 1e6); never below one cycle.
   localparam longint unsigned FREE_PRODUCT    = 64'(CLOCK_FREQUENCY / 1000) * 64'(BUS_FREE_TIME_NS);
   localparam longint unsigned FREE_CEIL       = (FREE_PRODUCT + 64'd999_999) / 64'd1_000_000;
   localparam longint unsigned BUS_FREE_CYCLES = (FREE_CEIL < 64'd1) ? 64'd1 : FREE_CEIL;
   localparam logic [31:0]     FREE_RELOAD     = 32'(BUS_FREE_CYCLES - 64'd1);

   typedef enum logic [1:0] {
      FREE_WAIT = 2'd0,
      IDLE      = 2'd1,
      GRANTED   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [31:0]           free_count_q, free_count_d;
   logic [PORT_COUNT-1:0] grant_q, grant_d;
   logic [2:0]            owner_q, owner_d;

   logic                  winner_found;
   logic [2:0]            winner_idx;
   logic                  owner_request;
   logic                  owner_scl;
   logic                  owner_sda;

   // Search order starts just after the last owner and wraps around.
   always_comb begin
      winner_found = 1'b0;
      winner_idx   = owner_q;
      for (int j = 1; j <= PORT_COUNT; j++) begin
         for (int k = 0; k < PORT_COUNT; k++) begin
            if (!winner_found && request[k] && (k == (int'(owner_q) + j) % PORT_COUNT)) begin
               winner_found = 1'b1;
               winner_idx   = 3'(k);
            end
         end
      end
   end

   always_comb begin
      owner_request = 1'b0;
      owner_scl     = 1'b1;
      owner_sda     = 1'b1;
      for (int k = 0; k < PORT_COUNT; k++) begin
         if (owner_q == 3'(k)) begin
            owner_request = request[k];
            owner_scl     = port_scl_output[k];
            owner_sda     = port_sda_output[k];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      free_count_d = free_count_q;
      grant_d      = grant_q;
      owner_d      = owner_q;
      unique case (state_q)
         FREE_WAIT: begin
            // Any low pad, ours or an external master's, restarts the quiet interval.
            if (!scl_input || !sda_input) begin
               free_count_d = FREE_RELOAD;
            end else if (free_count_q == 32'd0) begin
               state_d = IDLE;
            end else begin
               free_count_d = free_count_q - 32'd1;
            end
         end
         IDLE: begin
            if (winner_found) begin
               for (int k = 0; k < PORT_COUNT; k++) begin
                  grant_d[k] = (winner_idx == 3'(k));
               end
               owner_d = winner_idx;
               state_d = GRANTED;
            end
         end
         GRANTED: begin
            if (!owner_request) begin
               grant_d      = '0;
               free_count_d = FREE_RELOAD;
               state_d      = FREE_WAIT;
            end
         end
         default: begin
            grant_d      = '0;
            free_count_d = FREE_RELOAD;
            state_d      = FREE_WAIT;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= FREE_WAIT;
         free_count_q <= FREE_RELOAD;
         grant_q      <= '0;
         owner_q      <= 3'(PORT_COUNT - 1);
      end else begin
         state_q      <= state_d;
         free_count_q <= free_count_d;
         grant_q      <= grant_d;
         owner_q      <= owner_d;
      end
   end

   assign grant      = grant_q;
   assign owner      = owner_q;
   assign busy       = (grant_q != '0);
   assign scl_output = busy ? owner_scl : 1'b1;
   assign sda_output = busy ? owner_sda : 1'b1;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: directed corner cases, a pad-drive vector table and a
// randomized run, all checked every cycle against a quiet-time/round-robin reference model.
module tb_i2c_bus_arbiter;
   localparam int CLK_HZ  = 100_000_000;
   localparam int N       = 2;
   localparam int FREE_NS = 5000;
   localparam int FREE    = 500;   // 5 us of quiet bus at 100 MHz

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] request = '0;
   logic [N-1:0] grant;
   logic [N-1:0] port_scl_output = '1;
   logic [N-1:0] port_sda_output = '1;
   logic         scl_input = 1'b1;
   logic         sda_input = 1'b1;
   logic         scl_output;
   logic         sda_output;
   logic         busy;
   logic [2:0]   owner;

   always #5 clock = ~clock;

   i2c_bus_arbiter #(
      .CLOCK_FREQUENCY (CLK_HZ),
      .PORT_COUNT      (N),
      .BUS_FREE_TIME_NS(FREE_NS)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .request        (request),
      .grant          (grant),
      .port_scl_output(port_scl_output),
      .port_sda_output(port_sda_output),
      .scl_input      (scl_input),
      .sda_input      (sda_input),
      .scl_output     (scl_output),
      .sda_output     (sda_output),
      .busy           (busy),
      .owner          (owner)
   );

   int tests = 0;
   int failures = 0;
   int cycle = 0;

   // Reference model: who holds the bus, who held it last, how long the pads have been quiet.
   int m_grant = -1;
   int m_owner = N - 1;
   int m_quiet = 0;
   bit m_avail = 1'b0;

   int           wait_count[N];
   logic [N-1:0] prev_grant = '0;

   typedef struct {
      logic [N-1:0] p_scl;
      logic [N-1:0] p_sda;
      logic         e_scl;
      logic         e_sda;
   } pad_vec_t;
   pad_vec_t pad_tab[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
         if (failures >= 40) begin
            $display("[TB] %0d tests run, %0d failed", tests, failures);
            $finish;
         end
      end
   endtask

   function automatic int rr_distance(input int p);
      return (p - m_owner - 1 + 2 * N) % N;
   endfunction

   task automatic model_update();
      int best;
      best = -1;
      if (reset) begin
         m_grant = -1;
         m_owner = N - 1;
         m_quiet = 0;
         m_avail = 1'b0;
      end else if (m_grant >= 0) begin
         if (!request[m_grant]) begin
            m_grant = -1;
            m_quiet = 0;
            m_avail = 1'b0;
         end
      end else if (m_avail) begin
         if (request != '0) begin
            for (int p = 0; p < N; p++) begin
               if (request[p] && (best < 0 || rr_distance(p) < rr_distance(best))) best = p;
            end
            m_grant = best;
            m_owner = best;
            m_avail = 1'b0;
            $display("[TB] cycle %0d: port %0d granted", cycle + 1, best);
         end
      end else if (!scl_input || !sda_input) begin
         m_quiet = 0;
      end else begin
         m_quiet++;
         if (m_quiet >= FREE) m_avail = 1'b1;
      end
   endtask

   task automatic check_outputs();
      logic [N-1:0] eg;
      logic         ec;
      logic         ed;
      eg = (m_grant >= 0) ? (N'(1) << m_grant) : '0;
      ec = (m_grant >= 0) ? port_scl_output[m_grant] : 1'b1;
      ed = (m_grant >= 0) ? port_sda_output[m_grant] : 1'b1;
      chk("grant", 32'(grant), 32'(eg));
      chk("busy", 32'(busy), 32'(m_grant >= 0));
      chk("owner", 32'(owner), 32'(m_owner));
      chk("scl_output", 32'(scl_output), 32'(ec));
      chk("sda_output", 32'(sda_output), 32'(ed));
      // No waiting port may see more than N-1 other grants before its own.
      for (int p = 0; p < N; p++) begin
         if (reset || !request[p]) wait_count[p] = 0;
      end
      if (!reset && grant != '0 && prev_grant == '0) begin
         for (int p = 0; p < N; p++) begin
            if (grant[p]) begin
               wait_count[p] = 0;
            end else if (request[p]) begin
               wait_count[p]++;
               chk("starvation", 32'(wait_count[p] > N - 1), 32'd0);
            end
         end
      end
      prev_grant = grant;
   endtask

   task automatic step();
      model_update();
      @(posedge clock);
      #1;
      cycle++;
      check_outputs();
   endtask

   task automatic wait_grant(input int limit, output int waited);
      waited = 0;
      while (grant == '0 && waited < limit) begin
         step();
         waited++;
      end
      chk("grant_timeout", 32'(grant != '0), 32'd1);
   endtask

   initial begin
      int  w;
      int  cur;
      bit  flag;
      int  hold[N];
      logic [N-1:0] exp_g;

      pad_tab[0] = '{2'b11, 2'b11, 1'b1, 1'b1};
      pad_tab[1] = '{2'b01, 2'b10, 1'b1, 1'b0};
      pad_tab[2] = '{2'b00, 2'b10, 1'b0, 1'b0};
      pad_tab[3] = '{2'b10, 2'b00, 1'b0, 1'b0};
      pad_tab[4] = '{2'b01, 2'b01, 1'b1, 1'b1};
      pad_tab[5] = '{2'b11, 2'b00, 1'b1, 1'b0};
      pad_tab[6] = '{2'b00, 2'b11, 1'b0, 1'b1};
      pad_tab[7] = '{2'b10, 2'b10, 1'b0, 1'b0};
      for (int p = 0; p < N; p++) begin
         wait_count[p] = 0;
         hold[p] = 0;
      end

      // Reset state
      reset = 1'b1;
      repeat (3) step();
      chk("reset_grant", 32'(grant), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_owner", 32'(owner), 32'(N - 1));
      chk("reset_scl", 32'(scl_output), 32'd1);
      chk("reset_sda", 32'(sda_output), 32'd1);

      // First grant lands exactly 501 cycles after reset release
      reset   = 1'b0;
      request = 2'b01;
      flag    = 1'b0;
      for (int i = 0; i < FREE; i++) begin
         step();
         if (grant != '0 || !scl_output || !sda_output) flag = 1'b1;
      end
      chk("t1_quiet_before_grant", 32'(flag), 32'd0);
      step();
      chk("t1_grant_at_501", 32'(grant), 32'b01);

      // Pad drive follows the owner only
      for (int i = 0; i < 8; i++) begin
         port_scl_output = pad_tab[i].p_scl;
         port_sda_output = pad_tab[i].p_sda;
         #1;
         chk("t2_scl_vec", 32'(scl_output), 32'(pad_tab[i].e_scl));
         chk("t2_sda_vec", 32'(sda_output), 32'(pad_tab[i].e_sda));
         step();
      end
      port_scl_output = '1;
      port_sda_output = '1;

      // Second request arriving mid-transaction must wait
      request = 2'b11;
      flag = 1'b0;
      repeat (20) begin
         step();
         if (grant != 2'b01) flag = 1'b1;
      end
      chk("t5_grant_held", 32'(flag), 32'd0);
      request = 2'b10;
      step();
      chk("t5_grant_drop", 32'(grant), 32'd0);
      wait_grant(700, w);
      chk("t5_gap", 32'(w), 32'd501);
      chk("t5_port1", 32'(grant), 32'b10);

      // Both requesting: grants alternate with a full free interval between them
      request = 2'b11;
      cur = 1;
      for (int k = 0; k < 4; k++) begin
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         repeat (20) step();
         request[cur] = 1'b0;
         step();
         request[cur] = 1'b1;
         wait_grant(800, w);
         chk("t3_alternate", 32'(grant), 32'(exp_g));
         chk("t3_gap_ge_500", 32'(w >= FREE), 32'd1);
         cur = (k % 2 == 0) ? 0 : 1;
      end

      // One-cycle sda glitch 300 cycles into the free wait restarts it
      request = 2'b00;
      step();
      repeat (300) step();
      sda_input = 1'b0;
      step();
      sda_input = 1'b1;
      request = 2'b01;
      wait_grant(900, w);
      chk("t4_delay_ge_500", 32'(w >= FREE), 32'd1);
      chk("t4_grant", 32'(grant), 32'b01);

      // External master holding scl low stalls the arbiter indefinitely
      request = 2'b00;
      step();
      scl_input = 1'b0;
      request = 2'b10;
      flag = 1'b0;
      repeat (1500) begin
         step();
         if (grant != '0) flag = 1'b1;
      end
      chk("stall_no_grant", 32'(flag), 32'd0);
      scl_input = 1'b1;
      wait_grant(700, w);
      chk("stall_release_wait", 32'(w), 32'd501);
      chk("stall_grant", 32'(grant), 32'b10);

      // Reset in the middle of port 1's transaction
      port_scl_output = 2'b00;
      port_sda_output = 2'b00;
      step();
      chk("t6_pads_driven", 32'({scl_output, sda_output}), 32'd0);
      reset = 1'b1;
      step();
      chk("t6_grant_cleared", 32'(grant), 32'd0);
      chk("t6_busy_cleared", 32'(busy), 32'd0);
      chk("t6_pads_released", 32'({scl_output, sda_output}), 32'b11);
      reset = 1'b0;
      request = 2'b11;
      wait_grant(700, w);
      chk("t6_full_interval", 32'(w), 32'd501);
      chk("t6_port0_first", 32'(grant), 32'b01);
      request = 2'b00;
      step();

      // Randomized traffic against the model
      for (int c = 0; c < 30000; c++) begin
         for (int p = 0; p < N; p++) begin
            if (!request[p]) begin
               if ($urandom_range(0, 99) < 3) request[p] = 1'b1;
            end else if (m_grant == p) begin
               if (hold[p] == 0) begin
                  hold[p] = $urandom_range(1, 40);
               end else begin
                  hold[p]--;
                  if (hold[p] == 0) request[p] = 1'b0;
               end
            end else if ($urandom_range(0, 999) < 2) begin
               request[p] = 1'b0;
            end
         end
         port_scl_output = N'($urandom);
         port_sda_output = N'($urandom);
         scl_input = ($urandom_range(0, 4999) != 0);
         sda_input = ($urandom_range(0, 4999) != 0);
         reset     = ($urandom_range(0, 9999) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end
endmodule
